mux_scan_sequencer: RTL and testbench
=====================================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 0: extra wait cycles per channel after Sel changes, before sampling; legal range 0..15.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, synchronous and active-high.
REQ-004 Start  input  1  request one frame; sampled only in IDLE.
REQ-005 Stop  input  1  clears continuous mode; the current frame still completes.
REQ-006 Continuous  input  1  latched at Start; 1 means restart automatically after each accepted frame.
REQ-007 Mask  input  8  channel enables, latched at Start; bit n enables channel n.
REQ-008 Sel  output  3  channel select driven to the downstream 8:1 mux select input; registered.
REQ-009 Mux_In  input  1  selected bit returned from the 8:1 mux output.
REQ-010 Data  output  8  assembled frame; bit n is the channel-n sample, or 0 if channel n is masked.
REQ-011 Valid  output  1  Data is complete and stable.
REQ-012 Ready  input  1  consumer accepts Data when Valid is also high.
REQ-013 Busy  output  1  high in SCAN and HOLD.
REQ-014 Frame_Count  output  8  number of accepted frames; wraps from 255 to 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, SCAN and HOLD.
REQ-016 IDLE, Start=1 and Mask!=0: latch Mask and Continuous, load Sel with the lowest enabled channel, clear the Data shadow, then go to SCAN.
REQ-017 IDLE, Start=1 and Mask==0: ignore the request and stay in IDLE; Valid stays 0.
REQ-018 SCAN: each channel occupies 1+SETTLE_CYCLES cycles while Sel holds steady.
REQ-019 SCAN: Mux_In SHALL be sampled into bit Sel of the shadow on the last edge of each channel's dwell.
REQ-020 SCAN: after a sample, Sel SHALL advance to the next higher enabled channel; disabled channels are skipped and consume no cycles.
REQ-021 SCAN: the sample of the highest enabled channel SHALL end the frame. On that same edge, Data is loaded from the shadow, Valid goes to 1 and the FSM moves to HOLD.
REQ-022 Frame latency from the Start edge to Valid high SHALL be popcount(Mask)*(1+SETTLE_CYCLES) cycles.
REQ-023 HOLD: Data, Valid and Sel SHALL stay constant until Valid&&Ready.
REQ-024 HOLD with Valid&&Ready: increment Frame_Count and clear Valid on the same edge.
REQ-025 After acceptance in REQ-024: if the continuous latch is set, go to SCAN at the lowest enabled channel with no idle cycle; otherwise go to IDLE.
REQ-026 Stop=1 in any state SHALL clear the continuous latch.
REQ-027 Stop=1 in the same cycle as an accepting handshake SHALL send the FSM to IDLE.
REQ-028 Start and Stop together in IDLE SHALL produce a single-shot frame.
REQ-029 Start in SCAN or HOLD SHALL be ignored; Mask and Continuous changes after Start SHALL have no effect until the next Start.
REQ-030 Backpressure: no sampling occurs in HOLD, so no frame is ever overwritten or dropped.
REQ-031 In IDLE: Sel=0, Valid=0, Busy=0; Data keeps the last frame.
REQ-032 The dwell counter width SHALL be 4 bits; the channel index SHALL be 3 bits with no wrap inside a frame.

Reset
REQ-033 Rst=1 at an edge SHALL force: state IDLE, Sel=0, Data=0, Valid=0, Busy=0, Frame_Count=0, dwell counter=0, latched Mask=0, continuous latch=0.
REQ-034 Reset mid-SCAN or mid-HOLD SHALL abort the frame with no Valid pulse; Rst SHALL dominate Start, Stop and Ready.

Structure
REQ-035 A shared package SHALL hold the state enumeration (IDLE, SCAN, HOLD), CHAN_W=3 and NUM_CHAN=8.
REQ-036 One sub-module, chan_next_finder, SHALL be used. It is combinational: inputs mask[7:0], current index and a "first" flag; outputs the next enabled index and a last-channel flag.

Verification
REQ-037 Mask=8'hFF, SETTLE_CYCLES=0, Mux_In tied to a per-channel pattern giving 8'hA5, Ready=1, single shot -> Sel steps 0..7 on consecutive cycles; Valid after 8 cycles; Data=8'hA5; Frame_Count=1; then IDLE.
REQ-038 Mask=8'b1000_0101 with Mux_In=1 -> Sel visits only 0, 2, 7; latency 3 cycles; Data=8'h85.
REQ-039 SETTLE_CYCLES=2, Mask=8'h03 -> each Sel is held 3 cycles; Valid after 6 cycles.
REQ-040 Continuous=1, Ready held 0 for 5 cycles in HOLD, then Ready pulsed -> Data and Sel stable throughout HOLD; SCAN restarts on the next cycle with no gap; Frame_Count increments once per accepted frame; Stop asserted mid-frame ends the sequence in IDLE after that frame is accepted.
REQ-041 Rst asserted on the 4th SCAN cycle -> next cycle shows IDLE, all outputs 0, and no Valid pulse; also Start with Mask=0 -> Busy stays 0.
REQ-042 256 accepted frames -> Frame_Count wraps from 8'hFF to 8'h00.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// =====================================================================
// mux_scan_sequencer_pkg : shared types and sizes for the mux scanner
// Rev 1.0
// =====================================================================
`default_nettype none

package mux_scan_sequencer_pkg;

   localparam int CHAN_W   = 3;
   localparam int NUM_CHAN = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_scan_sequencer_chan_next_finder.sv
// =====================================================================
// chan_next_finder : next enabled channel above an index, or lowest
// enabled channel when i_first is set. Rev 1.0
// =====================================================================
`default_nettype none

module chan_next_finder
   import mux_scan_sequencer_pkg::*;
(
   input  logic [NUM_CHAN-1:0] i_mask,
   input  logic [CHAN_W-1:0]   i_idx,
   input  logic                i_first,
   output logic [CHAN_W-1:0]   o_next,
   output logic                o_last
);

   // Descending scan so the lowest qualifying channel is the final assignment.
   always_comb begin
      o_next = '0;
      o_last = 1'b1;
      for (int i = NUM_CHAN - 1; i >= 0; i--) begin
         if (i_mask[i] && (i_first || (i > int'(i_idx)))) begin
            o_next = i[CHAN_W-1:0];
         end
         if (i_mask[i] && (i > int'(i_idx))) begin
            o_last = 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// =====================================================================
// mux_scan_sequencer : steps an 8:1 mux select over enabled channels,
// assembles the sampled bits into a frame with valid/ready. Rev 1.0
// =====================================================================
`default_nettype none

module mux_scan_sequencer
   import mux_scan_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 0
)(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_continuous,
   input  logic [NUM_CHAN-1:0] i_mask,
   output logic [CHAN_W-1:0]   o_sel,
   input  logic                i_mux_in,
   output logic [NUM_CHAN-1:0] o_data,
   output logic                o_valid,
   input  logic                i_ready,
   output logic                o_busy,
   output logic [7:0]          o_frame_count
);

   localparam logic [3:0] c_settle = 4'(SETTLE_CYCLES);

   state_t              r_state, w_state_n;
   logic [CHAN_W-1:0]   r_sel, w_sel_n;
   logic [3:0]          r_dwell, w_dwell_n;
   logic [NUM_CHAN-1:0] r_mask, w_mask_n;
   logic                r_cont, w_cont_n;
   logic [NUM_CHAN-1:0] r_shadow, w_shadow_n;
   logic [NUM_CHAN-1:0] r_data, w_data_n;
   logic                r_valid, w_valid_n;
   logic [7:0]          r_fcnt, w_fcnt_n;

   logic [NUM_CHAN-1:0] w_find_mask;
   logic                w_find_first;
   logic [CHAN_W-1:0]   w_next;
   logic                w_last;
   logic [NUM_CHAN-1:0] w_sample;

   // In IDLE the live mask picks the first channel; otherwise the latched one.
   assign w_find_mask  = (r_state == ST_IDLE) ? i_mask : r_mask;
   assign w_find_first = (r_state != ST_SCAN);

   chan_next_finder u_finder (
      .i_mask  (w_find_mask),
      .i_idx   (r_sel),
      .i_first (w_find_first),
      .o_next  (w_next),
      .o_last  (w_last)
   );

   always_comb begin
      w_sample        = r_shadow;
      w_sample[r_sel] = i_mux_in;
   end

   always_comb begin
      w_state_n  = r_state;
      w_sel_n    = r_sel;
      w_dwell_n  = r_dwell;
      w_mask_n   = r_mask;
      w_cont_n   = r_cont & ~i_stop;
      w_shadow_n = r_shadow;
      w_data_n   = r_data;
      w_valid_n  = r_valid;
      w_fcnt_n   = r_fcnt;

      case (r_state)
         ST_IDLE: begin
            w_sel_n = '0;
            if (i_start && (i_mask != '0)) begin
               w_mask_n   = i_mask;
               w_cont_n   = i_continuous & ~i_stop;
               w_sel_n    = w_next;
               w_shadow_n = '0;
               w_dwell_n  = '0;
               w_state_n  = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (r_dwell == c_settle) begin
               w_dwell_n  = '0;
               w_shadow_n = w_sample;
               if (w_last) begin
                  w_data_n  = w_sample;
                  w_valid_n = 1'b1;
                  w_state_n = ST_HOLD;
               end else begin
                  w_sel_n = w_next;
               end
            end else begin
               w_dwell_n = r_dwell + 4'd1;
            end
         end
         ST_HOLD: begin
            if (r_valid && i_ready) begin
               w_valid_n = 1'b0;
               w_fcnt_n  = r_fcnt + 8'd1;
               if (r_cont && !i_stop) begin
                  w_state_n  = ST_SCAN;
                  w_sel_n    = w_next;
                  w_shadow_n = '0;
                  w_dwell_n  = '0;
               end else begin
                  w_state_n = ST_IDLE;
                  w_sel_n   = '0;
               end
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_sel_n   = '0;
            w_valid_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_sel    <= '0;
         r_dwell  <= '0;
         r_mask   <= '0;
         r_cont   <= 1'b0;
         r_shadow <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_fcnt   <= '0;
      end else begin
         r_state  <= w_state_n;
         r_sel    <= w_sel_n;
         r_dwell  <= w_dwell_n;
         r_mask   <= w_mask_n;
         r_cont   <= w_cont_n;
         r_shadow <= w_shadow_n;
         r_data   <= w_data_n;
         r_valid  <= w_valid_n;
         r_fcnt   <= w_fcnt_n;
      end
   end

   assign o_sel         = r_sel;
   assign o_data        = r_data;
   assign o_valid       = r_valid;
   assign o_busy        = (r_state != ST_IDLE);
   assign o_frame_count = r_fcnt;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// =====================================================================
// tb_mux_scan_sequencer : directed scoreboard bench for the mux scanner
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_mux_scan_sequencer;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] fcnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0;
   logic       start2 = 1'b0;
   logic       stop = 1'b0;
   logic       cont = 1'b0;
   logic [7:0] mask = 8'h00;
   logic       ready = 1'b0;
   logic [7:0] pat = 8'h00;

   logic [2:0] sel0, sel2;
   logic [7:0] data0, data2, fcnt0, fcnt2;
   logic       valid0, valid2, busy0, busy2;
   logic       mux0, mux2;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   assign mux0 = pat[sel0];
   assign mux2 = pat[sel2];

   mux_scan_sequencer #(.SETTLE_CYCLES(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_start(start0), .i_stop(stop),
      .i_continuous(cont), .i_mask(mask), .o_sel(sel0), .i_mux_in(mux0),
      .o_data(data0), .o_valid(valid0), .i_ready(ready), .o_busy(busy0),
      .o_frame_count(fcnt0)
   );

   mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_start(start2), .i_stop(stop),
      .i_continuous(cont), .i_mask(mask), .o_sel(sel2), .i_mux_in(mux2),
      .o_data(data2), .o_valid(valid2), .i_ready(ready), .o_busy(busy2),
      .o_frame_count(fcnt2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Monitor: every accepted frame is compared with the oldest expectation.
   always @(negedge clk) begin
      if (!rst && valid0 && ready) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected actual=%0h required=none", data0);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (data0 !== e.data || fcnt0 !== e.fcnt) begin
               bad++;
               $display("FAIL sb_frame actual=%0h/%0h required=%0h/%0h",
                        data0, fcnt0, e.data, e.fcnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      do_reset();
      chk("rst_sel",   32'(sel0),   32'd0);
      chk("rst_valid", 32'(valid0), 32'd0);
      chk("rst_busy",  32'(busy0),  32'd0);
      chk("rst_data",  32'(data0),  32'd0);
      chk("rst_fcnt",  32'(fcnt0),  32'd0);

      // Full mask, single shot, pattern A5
      pat = 8'hA5; mask = 8'hFF; cont = 1'b0; ready = 1'b1;
      q.push_back('{data: 8'hA5, fcnt: 8'd0});
      start0 = 1'b1; tick(); start0 = 1'b0;
      chk("a_busy", 32'(busy0), 32'd1);
      for (int k = 0; k < 8; k++) begin
         chk("a_sel",   32'(sel0),   32'(k));
         chk("a_valid", 32'(valid0), 32'd0);
         tick();
      end
      chk("a_valid_hi", 32'(valid0), 32'd1);
      chk("a_data",     32'(data0),  32'hA5);
      tick();
      chk("a_idle_busy", 32'(busy0),  32'd0);
      chk("a_idle_val",  32'(valid0), 32'd0);
      chk("a_idle_sel",  32'(sel0),   32'd0);
      chk("a_fcnt",      32'(fcnt0),  32'd1);
      chk("a_keep_data", 32'(data0),  32'hA5);

      // Sparse mask 1000_0101 with mux input high
      do_reset();
      pat = 8'hFF; mask = 8'b1000_0101;
      q.push_back('{data: 8'h85, fcnt: 8'd0});
      start0 = 1'b1; tick(); start0 = 1'b0;
      chk("b_sel0", 32'(sel0), 32'd0); chk("b_v0", 32'(valid0), 32'd0); tick();
      chk("b_sel2", 32'(sel0), 32'd2); chk("b_v1", 32'(valid0), 32'd0); tick();
      chk("b_sel7", 32'(sel0), 32'd7); chk("b_v2", 32'(valid0), 32'd0); tick();
      chk("b_valid", 32'(valid0), 32'd1);
      chk("b_data",  32'(data0),  32'h85);
      tick();

      // Settle of 2 cycles on the second instance, mask 03
      do_reset();
      pat = 8'h02; mask = 8'h03;
      start2 = 1'b1; tick(); start2 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("c_sel",   32'(sel2),   32'(k / 3));
         chk("c_valid", 32'(valid2), 32'd0);
         tick();
      end
      chk("c_valid_hi", 32'(valid2), 32'd1);
      chk("c_data",     32'(data2),  32'h02);
      tick();
      chk("c_fcnt", 32'(fcnt2), 32'd1);
      chk("c_busy", 32'(busy2), 32'd0);

      // Continuous with backpressure, then Stop mid-frame
      do_reset();
      pat = 8'h81; mask = 8'h81; cont = 1'b1; ready = 1'b0;
      start0 = 1'b1; tick(); start0 = 1'b0; cont = 1'b0; mask = 8'h00;
      tick(); tick();
      for (int k = 0; k < 5; k++) begin
         chk("d_hold_valid", 32'(valid0), 32'd1);
         chk("d_hold_data",  32'(data0),  32'h81);
         chk("d_hold_sel",   32'(sel0),   32'd7);
         tick();
      end
      q.push_back('{data: 8'h81, fcnt: 8'd0});
      pat = 8'h01; ready = 1'b1; tick(); ready = 1'b0;
      chk("d_restart_busy", 32'(busy0),  32'd1);
      chk("d_restart_val",  32'(valid0), 32'd0);
      chk("d_restart_sel",  32'(sel0),   32'd0);
      chk("d_fcnt1",        32'(fcnt0),  32'd1);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("d_sel7", 32'(sel0), 32'd7);
      tick();
      chk("d_valid2", 32'(valid0), 32'd1);
      chk("d_data2",  32'(data0),  32'h01);
      q.push_back('{data: 8'h01, fcnt: 8'd1});
      ready = 1'b1; tick();
      chk("d_end_busy", 32'(busy0), 32'd0);
      chk("d_fcnt2",    32'(fcnt0), 32'd2);

      // Reset on the 4th scan cycle, then Start with empty mask
      do_reset();
      pat = 8'hFF; mask = 8'hFF; ready = 1'b1;
      start0 = 1'b1; tick(); start0 = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("e_busy",  32'(busy0),  32'd0);
      chk("e_valid", 32'(valid0), 32'd0);
      chk("e_sel",   32'(sel0),   32'd0);
      chk("e_data",  32'(data0),  32'd0);
      chk("e_fcnt",  32'(fcnt0),  32'd0);
      for (int k = 0; k < 8; k++) begin
         chk("e_no_valid", 32'(valid0), 32'd0);
         tick();
      end
      mask = 8'h00; start0 = 1'b1; tick(); start0 = 1'b0;
      chk("e_m0_busy",  32'(busy0),  32'd0);
      tick();
      chk("e_m0_busy2", 32'(busy0),  32'd0);
      chk("e_m0_valid", 32'(valid0), 32'd0);

      // 256 continuous frames: Frame_Count wraps to 0
      do_reset();
      pat = 8'h01; mask = 8'h01; cont = 1'b1; ready = 1'b1;
      for (int i = 0; i < 256; i++) q.push_back('{data: 8'h01, fcnt: 8'(i)});
      start0 = 1'b1; tick(); start0 = 1'b0; cont = 1'b0;
      repeat (510) tick();
      chk("f_fcnt255", 32'(fcnt0),  32'hFF);
      chk("f_busy",    32'(busy0),  32'd1);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("f_valid",   32'(valid0), 32'd1);
      tick();
      chk("f_wrap",    32'(fcnt0),  32'd0);
      chk("f_idle",    32'(busy0),  32'd0);
      tick();
      chk("sb_empty",  32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
